// File: rtl/mod_sched_pkg.sv
// Shared ids, mode encodings and the in-flight tag type for the modulation multiplier scheduler.
// Pure declarations, so there is no latency and no backpressure.
package mod_sched_pkg;

  localparam logic [1:0] ID_AM = 2'd0;
  localparam logic [1:0] ID_FM = 2'd1;
  localparam logic [1:0] ID_PM = 2'd2;

  localparam logic [2:0] MODE_AM = 3'b001;
  localparam logic [2:0] MODE_FM = 3'b010;
  localparam logic [2:0] MODE_PM = 3'b011;

  typedef struct packed {
    logic       valid;
    logic [1:0] id;
  } tag_t;

  // Maps a mode to the single requester it enables; valid=0 means no modulation.
  function automatic tag_t mode_target(input logic [2:0] m);
    tag_t t;
    t = '0;
    case (m)
      MODE_AM: t = '{valid: 1'b1, id: ID_AM};
      MODE_FM: t = '{valid: 1'b1, id: ID_FM};
      MODE_PM: t = '{valid: 1'b1, id: ID_PM};
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr, plus the pointer to use after this grant.
// Combinational (zero latency); it only grants eligible requesters, so a requester waits until it is picked.
module rr_arbiter #(
  parameter int NREQ = 3,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   ptr_next
);

  logic found;
  int   idx;

  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        ptr_next    = PW'((idx + 1) % NREQ);
      end
    end
  end

endmodule

// File: rtl/mod_mult_scheduler.sv
// Shares one signed DWxDW multiplier among AM/FM/PM requesters; latency MULT_LAT+2, one op/cycle, ungranted requesters hold.
// MOD_SCHED_OFFSET_BIN_EN: treat operand B as offset-binary (MSB inverted before it reaches mult_b).
module mod_mult_scheduler
  import mod_sched_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int MULT_LAT = 1,
  parameter int DW       = 16
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic [2:0]        mode,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [DW-1:0]     mult_a,
  output logic [DW-1:0]     mult_b,
  input  logic [2*DW-1:0]   mult_result,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [2*DW-1:0]   rsp_data,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_next;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  tag_t            mode_tag;
  logic [2:0]      mode_q;
  logic            mode_chg;
  logic            any_grant;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic [DW-1:0]   b_in;
  logic [1:0]      sel_id;
  tag_t            tag_q [0:MULT_LAT];

  always_comb begin
    mode_tag = mode_target(mode);
    eligible = '0;
    for (int i = 0; i < NREQ; i++)
      eligible[i] = !rst && req_valid[i] && mode_tag.valid && (mode_tag.id == 2'(i));
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .ptr_next (ptr_next)
  );

  assign req_ready = grant;
  assign any_grant = |grant;
  assign mode_chg  = (mode != mode_q);

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a  = req_a[i*DW +: DW];
        sel_b  = req_b[i*DW +: DW];
        sel_id = 2'(i);
      end
    end
  end

`ifdef MOD_SCHED_OFFSET_BIN_EN
  assign b_in = sel_b ^ {1'b1, {(DW-1){1'b0}}};
`else
  assign b_in = sel_b;
`endif

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s <= MULT_LAT; s++)
      busy = busy | tag_q[s].valid;
  end

  // A mode change kills tags already in flight, but the grant made this cycle still enters stage 0.
  always_ff @(posedge clk_100M) begin
    mode_q <= mode;
    if (rst) begin
      ptr       <= '0;
      mult_a    <= '0;
      mult_b    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      for (int s = 0; s <= MULT_LAT; s++)
        tag_q[s] <= '0;
    end else begin
      ptr          <= ptr_next;
      mult_a       <= any_grant ? sel_a : '0;
      mult_b       <= any_grant ? b_in  : '0;
      tag_q[0]     <= '{valid: any_grant, id: sel_id};
      for (int s = 1; s <= MULT_LAT; s++)
        tag_q[s] <= '{valid: tag_q[s-1].valid && !mode_chg, id: tag_q[s-1].id};
      rsp_data  <= mult_result;
      rsp_valid <= '0;
      if (tag_q[MULT_LAT].valid && !mode_chg)
        rsp_valid[tag_q[MULT_LAT].id] <= 1'b1;
    end
  end

endmodule
